// File: rtl/wb_ldpc_regs.sv
// Wishbone register window for the LDPC codec: control/status, data-in/out vectors, GPIO signature.
// Optional macro WB_ERR_RESP_EN: unmapped offsets and writes to read-only registers get wbs_err_o instead of ack.
// Single-cycle ack/err one cycle after the request, never on two consecutive cycles.
module wb_ldpc_regs #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          N_WORDS   = 4,
   parameter logic [15:0] TIMEOUT   = 16'd4096
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_we_i,
   input  logic [3:0]             wbs_sel_i,
   input  logic [31:0]            wbs_adr_i,
   input  logic [31:0]            wbs_dat_i,
   output logic                   wbs_ack_o,
   output logic                   wbs_err_o,
   output logic [31:0]            wbs_dat_o,
   output logic [37:0]            io_out,
   output logic [37:0]            io_oeb,
   output logic                   core_start_o,
   output logic [32*N_WORDS-1:0]  core_din_o,
   input  logic                   core_done_i,
   input  logic                   core_ok_i,
   input  logic [32*N_WORDS-1:0]  core_dout_i
);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                     state_q;
   logic                       ack_q;
   logic [31:0]                dat_q;
   logic [15:0]                gpio_q;
   logic [15:0]                cnt_q;
   logic [15:0]                cycles_q;
   logic                       busy_q, done_q, ok_q, tmo_q, start_q;
   logic [N_WORDS-1:0][31:0]   din_q;
   logic [N_WORDS-1:0][31:0]   dout_q;

   // Address decode
   logic [7:0]          off;
   logic                in_win, req, bad, wr_ok, rd_ok;
   logic                hit_ctrl, hit_stat, hit_gpio, hit_cyc;
   logic [N_WORDS-1:0]  hit_din, hit_dout;
   logic [31:0]         wmask, rdata_d;
   logic                ctrl_start, ctrl_clr, clr_done, clr_tmo;

   assign off      = wbs_adr_i[7:0];
   assign in_win   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   assign hit_ctrl = (off == 8'h00);
   assign hit_stat = (off == 8'h04);
   assign hit_gpio = (off == 8'h08);
   assign hit_cyc  = (off == 8'h0C);
   assign wmask    = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

   // Per-word hits for the DIN and DOUT arrays
   always_comb begin
      hit_din  = '0;
      hit_dout = '0;
      for (int i = 0; i < N_WORDS; i++) begin
         hit_din[i]  = (off == 8'(16 + 4 * i));
         hit_dout[i] = (off == 8'(64 + 4 * i));
      end
   end

`ifdef WB_ERR_RESP_EN
   logic err_q;
   logic mapped;
   // A request must not land on the cycle an ack or err is already showing
   assign req    = wbs_stb_i & wbs_cyc_i & ~ack_q & ~err_q & in_win;
   assign mapped = hit_ctrl | hit_stat | hit_gpio | hit_cyc | (|hit_din) | (|hit_dout);
   // STATUS bits 0 and 2 are hardware-owned, so attempting to write a 1 there is an error
   assign bad    = ~mapped | (wbs_we_i & (hit_cyc | (|hit_dout) |
                   (hit_stat & wbs_sel_i[0] & (wbs_dat_i[0] | wbs_dat_i[2]))));
   assign wbs_err_o = err_q;
`else
   assign req       = wbs_stb_i & wbs_cyc_i & ~ack_q & in_win;
   assign bad       = 1'b0;
   assign wbs_err_o = 1'b0;
`endif

   assign wr_ok      = req & wbs_we_i & ~bad;
   assign rd_ok      = req & ~wbs_we_i & ~bad;
   assign ctrl_start = wr_ok & hit_ctrl & wbs_sel_i[0] & wbs_dat_i[0];
   assign ctrl_clr   = wr_ok & hit_ctrl & wbs_sel_i[0] & wbs_dat_i[1];
   assign clr_done   = wr_ok & hit_stat & wbs_sel_i[0] & wbs_dat_i[1];
   assign clr_tmo    = wr_ok & hit_stat & wbs_sel_i[0] & wbs_dat_i[3];

   // Read mux; CTRL and unmapped offsets read as zero
   always_comb begin
      rdata_d = 32'h0;
      if (hit_stat)      rdata_d = {28'h0, tmo_q, ok_q, done_q, busy_q};
      else if (hit_gpio) rdata_d = {16'h0, gpio_q};
      else if (hit_cyc)  rdata_d = {16'h0, cycles_q};
      for (int i = 0; i < N_WORDS; i++) begin
         if (hit_din[i])  rdata_d = din_q[i];
         if (hit_dout[i]) rdata_d = dout_q[i];
      end
   end

   // Bus response: ack (or err) and read data registered one cycle after the request
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= 32'h0;
`ifdef WB_ERR_RESP_EN
         err_q <= 1'b0;
`endif
      end else begin
         ack_q <= req & ~bad;
         dat_q <= rd_ok ? rdata_d : 32'h0;
`ifdef WB_ERR_RESP_EN
         err_q <= req & bad;
`endif
      end
   end

   // Firmware-owned registers: GPIO signature and the data-in vector, byte-lane gated
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         gpio_q <= 16'h0;
         din_q  <= '0;
      end else begin
         if (wr_ok & hit_gpio)
            gpio_q <= (gpio_q & ~wmask[15:0]) | (wbs_dat_i[15:0] & wmask[15:0]);
         for (int i = 0; i < N_WORDS; i++) begin
            if (wr_ok & hit_din[i])
               din_q[i] <= (din_q[i] & ~wmask) | (wbs_dat_i & wmask);
         end
      end
   end

   // Operation sequencer: start, completion, timeout and abort, plus the status it reports
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 16'h0;
         cycles_q <= 16'h0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         ok_q     <= 1'b0;
         tmo_q    <= 1'b0;
         start_q  <= 1'b0;
         dout_q   <= '0;
      end else begin
         start_q <= 1'b0;
         if (clr_done) done_q <= 1'b0;
         if (clr_tmo)  tmo_q  <= 1'b0;
         if (ctrl_clr) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            tmo_q   <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (ctrl_start) begin
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                     ok_q    <= 1'b0;
                     tmo_q   <= 1'b0;
                     cnt_q   <= 16'h0;
                     start_q <= 1'b1;
                     state_q <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  cnt_q <= cnt_q + 16'd1;
                  // Completion takes priority over a timeout on the same cycle
                  if (core_done_i) begin
                     dout_q   <= core_dout_i;
                     ok_q     <= core_ok_i;
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                     cycles_q <= cnt_q + 16'd1;
                     state_q  <= ST_IDLE;
                  end else if (cnt_q == TIMEOUT - 16'd1) begin
                     tmo_q    <= 1'b1;
                     busy_q   <= 1'b0;
                     cycles_q <= TIMEOUT;
                     state_q  <= ST_IDLE;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign wbs_ack_o    = ack_q;
   assign wbs_dat_o    = dat_q;
   assign core_start_o = start_q;
   assign core_din_o   = din_q;
   assign io_out       = {6'h00, gpio_q, 16'h0000};
   assign io_oeb       = {6'h3F, 16'h0000, 16'hFFFF};

endmodule

// File: tb/tb_wb_ldpc_regs.sv
// Directed bench for wb_ldpc_regs: GPIO, data path, completion, timeout, abort and reset.
// Bus transfers take two cycles; outputs are sampled 1 time unit after the rising edge.
// The codec is modelled inline by driving core_done_i on hand-computed cycles.
module tb_wb_ldpc_regs;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int          N    = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           stb, cyc, we;
   logic [3:0]     sel;
   logic [31:0]    adr, dat_i;
   logic           ack, err;
   logic [31:0]    dat_o;
   logic [37:0]    io_out, io_oeb;
   logic           core_start;
   logic [32*N-1:0] core_din;
   logic           core_done, core_ok;
   logic [32*N-1:0] core_dout;

   int             n_pass  = 0;
   int             n_total = 0;
   int             start_cnt = 0;
   logic           last_ack, last_err, post_resp, last_start;
   logic [31:0]    last_dat;

   wb_ldpc_regs #(.BASE_ADDR(BASE), .N_WORDS(N), .TIMEOUT(16'd4096)) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .wbs_stb_i    (stb),
      .wbs_cyc_i    (cyc),
      .wbs_we_i     (we),
      .wbs_sel_i    (sel),
      .wbs_adr_i    (adr),
      .wbs_dat_i    (dat_i),
      .wbs_ack_o    (ack),
      .wbs_err_o    (err),
      .wbs_dat_o    (dat_o),
      .io_out       (io_out),
      .io_oeb       (io_oeb),
      .core_start_o (core_start),
      .core_din_o   (core_din),
      .core_done_i  (core_done),
      .core_ok_i    (core_ok),
      .core_dout_i  (core_dout)
   );

   always #5 clk = ~clk;

   // Count start pulses, sampled mid-cycle
   always @(negedge clk) if (core_start) start_cnt++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // One request; records the response seen one cycle later and whether it lingered
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      tick();
      last_ack = ack; last_err = err; last_dat = dat_o; last_start = core_start;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      tick();
      post_resp = ack | err;
   endtask

   initial begin
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
      adr = 32'h0; dat_i = 32'h0;
      core_done = 1'b0; core_ok = 1'b0; core_dout = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_ack", ack, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_dat", dat_o, 32'h0);
      chk("rst_start", core_start, 1'b0);
      chk("rst_io_out", io_out, 38'h0);
      chk("rst_io_oeb", io_oeb, 38'h3F_0000_FFFF);
      chk("rst_din", core_din, 128'h0);
      rst = 1'b0;
      tick();

      // GPIO write and readback
      xfer(1'b1, BASE + 32'h08, 32'h0000_AB60, 4'hF);
      chk("gpio_wr_ack", last_ack, 1'b1);
      chk("gpio_wr_ack_once", post_resp, 1'b0);
      chk("gpio_wr_err", last_err, 1'b0);
      chk("gpio_io_out", io_out[31:16], 16'hAB60);
      chk("gpio_io_oeb", io_oeb, 38'h3F_0000_FFFF);
      xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF);
      chk("gpio_rd", last_dat, 32'h0000_AB60);

      // Data-in vector
      xfer(1'b1, BASE + 32'h10, 32'h1111_1111, 4'hF);
      xfer(1'b1, BASE + 32'h14, 32'h2222_2222, 4'hF);
      xfer(1'b1, BASE + 32'h18, 32'h3333_3333, 4'hF);
      xfer(1'b1, BASE + 32'h1C, 32'h4444_4444, 4'hF);
      chk("din_vec", core_din, 128'h44444444_33333333_22222222_11111111);
      xfer(1'b0, BASE + 32'h18, 32'h0, 4'hF);
      chk("din2_rd", last_dat, 32'h3333_3333);

      // Normal completion: done sampled on the 10th RUN cycle
      xfer(1'b1, BASE + 32'h00, 32'h1, 4'hF);
      chk("start_pulse", last_start, 1'b1);
      xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF);
      chk("status_busy", last_dat, 32'h1);
      repeat (6) tick();
      core_done = 1'b1; core_ok = 1'b1;
      core_dout = ~128'h44444444_33333333_22222222_11111111;
      tick();
      core_done = 1'b0; core_ok = 1'b0;
      tick();
      chk("start_count1", start_cnt, 1);
      xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF);
      chk("status_done_ok", last_dat, 32'h6);
      xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF);
      chk("dout0", last_dat, 32'hEEEE_EEEE);
      xfer(1'b0, BASE + 32'h4C, 32'h0, 4'hF);
      chk("dout3", last_dat, 32'hBBBB_BBBB);
      xfer(1'b0, BASE + 32'h0C, 32'h0, 4'hF);
      chk("cycles_done", last_dat, 32'd10);

      // Timeout with a silent core; second START during RUN is ignored
      core_dout = {4{32'h5555_5555}};
      xfer(1'b1, BASE + 32'h00, 32'h1, 4'hF);
      xfer(1'b1, BASE + 32'h00, 32'h1, 4'hF);
      repeat (4092) tick();
      xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF);
      chk("status_last_busy", last_dat, 32'h1);
      xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF);
      chk("status_timeout", last_dat, 32'h8);
      xfer(1'b0, BASE + 32'h0C, 32'h0, 4'hF);
      chk("cycles_timeout", last_dat, 32'd4096);
      xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF);
      chk("dout_kept", last_dat, 32'hEEEE_EEEE);
      chk("start_count2", start_cnt, 2);
      xfer(1'b1, BASE + 32'h04, 32'h8, 4'hF);
      xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF);
      chk("status_w1c", last_dat, 32'h0);

      // CLR five cycles into RUN; a late done is ignored
      xfer(1'b1, BASE + 32'h00, 32'h1, 4'hF);
      repeat (3) tick();
      xfer(1'b1, BASE + 32'h00, 32'h2, 4'hF);
      xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF);
      chk("status_clr", last_dat, 32'h0);
      core_done = 1'b1; core_ok = 1'b1; core_dout = {4{32'h7777_7777}};
      tick();
      core_done = 1'b0; core_ok = 1'b0;
      xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF);
      chk("status_idle_done", last_dat, 32'h0);
      xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF);
      chk("dout_after_clr", last_dat, 32'hEEEE_EEEE);
      chk("start_count3", start_cnt, 3);

      // Byte-lane gating and unmapped / out-of-window accesses
      xfer(1'b1, BASE + 32'h08, 32'h0000_1234, 4'hF);
      xfer(1'b1, BASE + 32'h08, 32'h0000_FFFF, 4'b0001);
      xfer(1'b0, BASE + 32'h08, 32'h0, 4'hF);
      chk("gpio_sel_rd", last_dat, 32'h0000_12FF);
      chk("gpio_sel_io", io_out[31:16], 16'h12FF);
      xfer(1'b0, BASE + 32'h3C, 32'h0, 4'hF);
      chk("unmapped_dat", last_dat, 32'h0);
`ifdef WB_ERR_RESP_EN
      chk("unmapped_err", last_err, 1'b1);
      chk("unmapped_noack", last_ack, 1'b0);
`else
      chk("unmapped_ack", last_ack, 1'b1);
      chk("unmapped_noerr", last_err, 1'b0);
`endif
      xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF);
      chk("outwin_ack", last_ack, 1'b0);
      chk("outwin_err", last_err, 1'b0);

      // Reset in the middle of RUN
      xfer(1'b1, BASE + 32'h00, 32'h1, 4'hF);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("mrst_ack", ack, 1'b0);
      chk("mrst_start", core_start, 1'b0);
      chk("mrst_io_out", io_out, 38'h0);
      chk("mrst_io_oeb", io_oeb, 38'h3F_0000_FFFF);
      chk("mrst_din", core_din, 128'h0);
      rst = 1'b0;
      tick();
      xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF);
      chk("mrst_status", last_dat, 32'h0);
      xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF);
      chk("mrst_dout", last_dat, 32'h0);
      xfer(1'b0, BASE + 32'h0C, 32'h0, 4'hF);
      chk("mrst_cycles", last_dat, 32'h0);
      core_done = 1'b1; core_ok = 1'b1;
      tick();
      core_done = 1'b0; core_ok = 1'b0;
      xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF);
      chk("mrst_idle", last_dat, 32'h0);
      chk("start_count4", start_cnt, 4);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_ldpc_regs.md
Name: wb_ldpc_regs

Overview:
- Wishbone classic responder in the user project area; the management SoC firmware is the initiator.
- Exposes control/status, data-in and data-out registers for the LDPC codec core, and sequences core start, completion and timeout.
- Owns the 16-bit firmware-written signature field driven onto user GPIO mprj_io[31:16], which the chip-level benches monitor.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the register window; the block decodes wbs_adr_i[31:8] == BASE_ADDR[31:8].
- N_WORDS, 4, number of 32-bit words per data vector; range 1..8.
- TIMEOUT, 16'd4096, cycles allowed in RUN before abort.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; synchronous, active-high
- wbs_stb_i  in  1  strobe
- wbs_cyc_i  in  1  cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte enables
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_err_o  out  1  error response; see Optional Feature
- wbs_dat_o  out  32  read data
- io_out  out  38  GPIO output values
- io_oeb  out  38  GPIO output enables, active-low
- core_start_o  out  1  one-cycle start pulse to the codec
- core_din_o  out  32*N_WORDS  data-in vector; word i occupies bits [32i+31:32i]
- core_done_i  in  1  one-cycle completion pulse from the codec
- core_ok_i  in  1  codec pass flag; valid with core_done_i
- core_dout_i  in  32*N_WORDS  codec result; valid with core_done_i

Behaviour:
Register map (offset from base):
- 0x00 CTRL (write-only, reads 0). bit0 START: self-clearing. bit1 CLR: aborts any operation and clears all STATUS bits.
- 0x04 STATUS (read-only). bit0 busy; bit1 done (sticky); bit2 ok; bit3 timeout (sticky). Writing 1 to bit1 or bit3 clears that bit.
- 0x08 GPIO (read/write). Bits [15:0] only.
- 0x0C CYCLES (read-only). Cycle count of the last completed or aborted operation.
- 0x10 + 4i, i < N_WORDS: DIN[i] (read/write).
- 0x40 + 4i, i < N_WORDS: DOUT[i] (read-only).
- Any other offset inside the window: read 0, writes ignored.

Wishbone:
- A request is stb & cyc & !ack, sampled at a rising edge.
- The write takes effect on that same edge. wbs_ack_o is high for exactly the following cycle, with read data registered alongside it.
- Ack is never held for two consecutive cycles; a back-to-back request is therefore served every second cycle.
- Byte lanes are gated by wbs_sel_i on all read/write registers.
- Addresses outside the window are not acknowledged.

FSM, states IDLE and RUN:
- IDLE: a START write sets busy=1, done=0, ok=0, timeout=0, cnt=0 and pulses core_start_o one cycle later; next state RUN.
- RUN: cnt increments every cycle.
  - On core_done_i: latch DOUT and ok, done=1, busy=0, CYCLES=cnt+1, next state IDLE.
  - When cnt reaches TIMEOUT-1 without done: timeout=1, busy=0, CYCLES=TIMEOUT, next state IDLE, and DOUT is unchanged.
  - If core_done_i and the timeout occur in the same cycle, done wins.
- START while in RUN is ignored.
- A DIN write during RUN is accepted, but the core sees the new value only on the next start.
- CLR in any state: next state IDLE, busy=0, and all STATUS bits cleared. DOUT and GPIO are retained.
- core_done_i received while in IDLE is ignored.

GPIO:
- io_out[31:16] = GPIO[15:0]; io_oeb[31:16] = 0.
- All other io_out bits = 0; all other io_oeb bits = 1.

Reset: all registers, DIN, DOUT, CYCLES, GPIO and cnt = 0. wbs_ack_o = 0, wbs_err_o = 0, wbs_dat_o = 0, core_start_o = 0. State = IDLE. Reset asserted during RUN aborts without a done or timeout flag.

Optional Feature:
Macro WB_ERR_RESP_EN.
- Defined: an in-window access to an unmapped offset, or a write to a read-only register (STATUS bit0/2, CYCLES, DOUT), returns wbs_err_o for one cycle in place of wbs_ack_o. Same timing as ack; no state change; read data 0.
- Undefined: wbs_err_o is tied to 0, and such accesses are acknowledged normally as described above.

Test Plan:
- Write 0x0000AB60 to 0x08, sel=4'hF -> ack exactly 1 cycle later; io_out[31:16]=16'hAB60 from the next cycle; io_oeb[31:16]=0; readback of 0x08 = 0x0000AB60.
- Write DIN[0..3]=0x11111111..0x44444444, then START; model returns done after 10 cycles with ok=1 and dout=~din -> STATUS reads 0x6, DOUT[0]=0xEEEEEEEE, CYCLES=10, core_start_o pulsed once.
- START with the core never responding -> after TIMEOUT=4096 cycles STATUS=0x8, CYCLES=4096, DOUT unchanged; a second START during RUN produces no extra core_start_o pulse.
- CLR written 5 cycles into RUN -> busy=0, STATUS=0; a later core_done_i does not set done.
- Write 0x0000FFFF to 0x08 with sel=4'b0001 over an old value of 0x00001234 -> register reads 0x000012FF; a read of offset 0x3C returns 0 (err instead of ack with WB_ERR_RESP_EN).
- Reset pulse mid-RUN -> all outputs at their reset values; state IDLE; io_out[31:16]=0.
